// File: rtl/io_out_fifo.sv
// Per-port elastic output buffer behind io_switch: a first-word-fall-through FIFO
// with occupancy flags and a saturating back-pressure cycle counter.
module io_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [15:0]                stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("io_out_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("io_out_fifo: AF_THRESH must lie in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    // in_ready looks only at registered count, so a pop never frees a slot in the same cycle.
    always_comb begin
        empty       = (count == '0);
        full        = (count == CW'(DEPTH));
        almost_full = (count >= CW'(AF_THRESH));
        in_ready    = !full && !rst;
        out_valid   = !empty && !rst;
        out_data    = out_valid ? mem[rd_ptr] : '0;
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Debug counter survives flush; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/io_out_fifo.md
Name: io_out_fifo

Overview:
- Per-port elastic output buffer that sits directly downstream of io_switch, with one instance on each out_data_N/out_valid_N/out_ready_N port.
- Absorbs consumer back-pressure so a slow sink does not stall the switch fabric on every cycle.
- First-word-fall-through FIFO with occupancy/status flags and a saturating back-pressure cycle counter for debug.

Parameters:
- DATA_WIDTH, 32, width of the stream data word (matches io_switch).
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of FIFO contents.
- in_data  input  DATA_WIDTH  write data, from io_switch out_data_N.
- in_valid  input  1  write request, from io_switch out_valid_N.
- in_ready  output  1  FIFO can accept a word; drives io_switch out_ready_N.
- out_data  output  DATA_WIDTH  head-of-FIFO data.
- out_valid  output  1  head word present.
- out_ready  input  1  downstream consumer accepts the head word.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- All state updates on posedge clk only.
- Reset (rst=1), required values on the next edge:
  - wr_ptr=0, rd_ptr=0, count=0, stall_cnt=0.
  - Storage array is not reset.
  - While rst is high: in_ready forced 0, out_valid=0, out_data=0.
  - After reset: empty=1, full=0, almost_full=0, in_ready=1.
- Push: in_valid && in_ready. Writes mem[wr_ptr] and increments wr_ptr.
- Pop: out_valid && out_ready. Increments rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready = !full && !rst. It is derived from registered count only, with no combinational path from out_ready.
  - When full, a simultaneous pop does NOT allow a same-cycle push; in_ready stays 0 for that cycle.
- out_valid = !empty. out_data = mem[rd_ptr] when !empty, else all-zero.
- Latency: a word pushed into an empty FIFO appears on out_data with out_valid=1 on the cycle after the push edge (1 cycle). There is no bypass path.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged (both pointers advance).
  - neither: unchanged.
- Status flags (empty, full, almost_full) are combinational decodes of registered count.
- Ordering: strict FIFO. No word is duplicated or dropped except by flush or rst.
- Flush (flush=1, rst=0):
  - On the edge: wr_ptr=rd_ptr=0 and count=0.
  - Overrides any push or pop in the same cycle. The input word offered that cycle is discarded; in_ready still reflects pre-flush state.
  - stall_cnt is not cleared by flush.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Holds at 16'hFFFF once reached.
  - Cleared only by rst.
- rst mid-operation: contents are lost and the next cycle shows the reset values above. A push or pop during an rst cycle has no effect.
- AF_THRESH > DEPTH or non-power-of-two DEPTH is illegal (elaboration-time check).

Test Plan:
- Reset/idle: assert rst 2 cycles, release -> count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0, stall_cnt=0.
- Fill: DEPTH=8, out_ready=0, push 0x11..0x88 on consecutive cycles:
  - almost_full rises when count=6; full and in_ready=0 after the 8th push.
  - A 9th in_valid with 0x99 is not accepted.
  - stall_cnt increments each cycle out_valid=1.
- Drain with wrap: from full, pop 3 (0x11,0x22,0x33), push 0xA1,0xA2,0xA3, then drain all -> output order 0x44..0x88 then 0xA1..0xA3; count returns to 0.
- Simultaneous: count=4, push and pop together for 10 cycles with incrementing data -> count stays 4, output sequence contiguous. At full with out_ready=1, in_ready=0 on that cycle.
- Flush: count=5, assert flush with in_valid=1, out_ready=1 -> next cycle count=0, empty=1; the flush-cycle word never appears on the output; stall_cnt retained.
- Saturation: hold out_ready=0 with one word queued for 70000 cycles -> stall_cnt=16'hFFFF and stays. rst -> 0.
